// File: rtl/fp_decoder.sv
// fp_decoder: multi-cycle float {S, E[2:0], F[4:0]} to OUT_W-bit two's-complement
// decoder. The value (-1)^S * F * 2^E is rebuilt by shifting F left once per cycle.
// Optional build macro FPDEC_SATURATE_EN: when defined, overflowing results clamp
// to the most positive/negative code; when undefined they wrap (low OUT_W bits).
// OUT_W is intended to lie in 9..16.
module fp_decoder #(
    parameter int OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             S,
    input  logic [2:0]       E,
    input  logic [4:0]       F,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] D,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SIGN  = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Magnitude limits, expressed in the OUT_W+1 bit magnitude domain.
    localparam logic [OUT_W:0]   POS_MAX = {2'b00, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W:0]   NEG_MAX = {2'b01, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    state_t           state_q, state_d;
    logic [OUT_W:0]   mag_q, mag_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             s_q, s_d;
    logic             sticky_q, sticky_d;
    logic [OUT_W-1:0] d_q, d_d;
    logic             ovf_q, ovf_d;

    logic             over;
    logic [OUT_W-1:0] wrapped;

    // State and datapath registers; reset aborts any in-flight conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mag_q    <= '0;
            cnt_q    <= '0;
            s_q      <= 1'b0;
            sticky_q <= 1'b0;
            d_q      <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mag_q    <= mag_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            sticky_q <= sticky_d;
            d_q      <= d_d;
            ovf_q    <= ovf_d;
        end
    end

    // Range check and signed result; only low OUT_W magnitude bits matter for negation.
    always_comb begin
        over    = sticky_q | (s_q ? (mag_q > NEG_MAX) : (mag_q > POS_MAX));
        wrapped = s_q ? (~mag_q[OUT_W-1:0] + 1'b1) : mag_q[OUT_W-1:0];
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        cnt_d    = cnt_q;
        s_d      = s_q;
        sticky_d = sticky_q;
        d_d      = d_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d      = S;
                    mag_d    = (OUT_W+1)'(F);
                    cnt_d    = E;
                    sticky_d = 1'b0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != 3'd0) begin
                    mag_d = {mag_q[OUT_W-1:0], 1'b0};
                    cnt_d = cnt_q - 3'd1;
                    if (mag_q[OUT_W]) begin
                        sticky_d = 1'b1;
                    end
                end else begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                ovf_d = over;
`ifdef FPDEC_SATURATE_EN
                if (over) begin
                    d_d = s_q ? SAT_NEG : SAT_POS;
                end else begin
                    d_d = wrapped;
                end
`else
                d_d = wrapped;
`endif
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifndef FPDEC_SATURATE_EN
    // Clamp codes are only needed in the saturating build.
    logic sat_unused;
    assign sat_unused = ^{SAT_POS, SAT_NEG};
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign D         = d_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fp_decoder.sv
// Bench for fp_decoder (OUT_W=12): directed test-plan vectors, backpressure,
// mid-conversion reset and randomized floats against an arithmetic reference.
module tb_fp_decoder;

    localparam int OW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          S_i = 1'b0;
    logic [2:0]    E_i = '0;
    logic [4:0]    F_i = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] D;
    logic          ovf;

    int tests = 0;
    int failed = 0;

    fp_decoder #(.OUT_W(OW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S_i),
        .E         (E_i),
        .F         (F_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer value, range test, then clamp or wrap.
    task automatic model(input bit s, input int e, input int f,
                         output logic [OW-1:0] d, output bit o);
        int mag;
        int val;
        int vmax;
        int vmin;
        mag  = f * (1 << e);
        val  = s ? -mag : mag;
        vmax = (1 << (OW-1)) - 1;
        vmin = -(1 << (OW-1));
        o    = (val > vmax) || (val < vmin);
`ifdef FPDEC_SATURATE_EN
        if (o) d = s ? OW'(vmin) : OW'(vmax);
        else   d = OW'(val);
`else
        d = OW'(val);
`endif
    endtask

    task automatic xfer(input bit s, input int e, input int f, input int bp);
        logic [OW-1:0] de;
        bit oe;
        int lat;
        bit seen;
        model(s, e, f, de, oe);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        S_i       = s;
        E_i       = 3'(e);
        F_i       = 5'(f);
        out_ready = (bp == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        S_i      = 1'($urandom);
        E_i      = 3'($urandom);
        F_i      = 5'($urandom);
        chk("in_ready_busy", in_ready, 0);
        lat  = 0;
        seen = 0;
        while (!seen && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            seen = out_valid;
        end
        chk("valid_seen", seen, 1);
        chk("latency", lat, e + 2);
        chk("D", D, de);
        chk("ovf", ovf, oe);
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_D", D, de);
            chk("hold_ovf", ovf, oe);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("valid_drop", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        bit quiet;

        // Async reset assert, then sync release.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_D", D, 0);
        chk("rst_ovf", ovf, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed test-plan vectors.
        xfer(1'b0, 3, 22, 0);
        xfer(1'b1, 0, 1, 0);
        xfer(1'b1, 5, 0, 0);
        xfer(1'b1, 6, 31, 0);
        xfer(1'b1, 7, 16, 0);
        xfer(1'b0, 7, 31, 0);
        xfer(1'b0, 6, 31, 0);
        xfer(1'b1, 7, 31, 0);
        // Backpressure, then back-to-back acceptance.
        xfer(1'b0, 2, 13, 4);
        xfer(1'b1, 4, 9, 0);

        // Reset during SHIFT of an E=7 conversion (previous D is non-zero).
        @(negedge clk);
        in_valid = 1'b1;
        S_i = 1'b0; E_i = 3'd7; F_i = 5'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_D", D, 0);
        chk("mid_rst_ovf", ovf, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) quiet = 1'b0;
        end
        chk("no_stale_output", quiet, 1);
        xfer(1'b0, 1, 3, 0);

        // Randomized floats with random backpressure.
        for (int n = 0; n < 40; n++) begin
            xfer(1'($urandom), int'($urandom_range(7, 0)), int'($urandom_range(31, 0)),
                 int'($urandom_range(3, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fp_decoder.md
# fp_decoder

Multi-cycle floating-point to two's-complement decoder, the inverse path of the converter's encoder/rounder stage. Accepts one 9-bit float {S, E[2:0], F[4:0]}, value = (-1)^S × F × 2^E. Rebuilds the integer by shifting F left one bit per cycle, E times, then applies the sign. Delivers an OUT_W-bit two's-complement word over a valid/ready handshake. Sits downstream of the float datapath, so stored or transmitted floats can be turned back into linear samples.

## Interface
- OUT_W, 12: output width in bits. Legal range is 9 to 16.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input float present
- in_ready  out  1  decoder can accept; high only in IDLE
- S  in  1  sign
- E  in  3  exponent, 0 to 7
- F  in  5  significand, unsigned integer 0 to 31
- out_valid  out  1  D and ovf valid
- out_ready  in  1  consumer takes result
- D  out  OUT_W  two's-complement result
- ovf  out  1  true magnitude exceeded the OUT_W range

## Operation
- FSM states: IDLE, SHIFT, SIGN, OUT.
- **IDLE**
  - in_ready=1.
  - On in_valid&in_ready: capture S, load mag={zeros,F} (OUT_W+1 bits), load cnt=E, clear the sticky overflow bit. Go to SHIFT.
- **SHIFT**
  - If cnt≠0: mag←mag<<1 and cnt←cnt-1.
  - Overflow bit goes sticky-set if a 1 is shifted past bit OUT_W of mag.
  - If cnt==0: go to SIGN, mag unchanged.
- **SIGN**
  - Overflow limits: positive mag > 2^(OUT_W-1)-1, or negative mag > 2^(OUT_W-1), or the sticky bit is set.
  - Register D = S ? -mag : mag, truncated to OUT_W bits.
  - Register ovf. Go to OUT.
- **OUT**
  - out_valid=1. D and ovf are held stable.
  - On out_ready: go to IDLE.
- Negative zero (S=1, F=0) yields D=0, ovf=0.
- Input fields are sampled only at the accept edge. Changes afterwards are ignored.

## Timing
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, D=0, ovf=0, mag=0, cnt=0.
- Accept at edge k. out_valid rises at edge k+E+2 (1 SHIFT cycle per exponent step, plus the cnt==0 SHIFT cycle, plus SIGN).
- Latency for E=0 is 2 cycles, and for E=7 it is 9 cycles.
- out_valid stays high until the edge where out_ready=1. It drops the next cycle.
- in_ready rises the cycle after the output handshake. There is no overlap: throughput is one float per E+3 cycles minimum.
- out_ready can be held high permanently, so OUT lasts one cycle.
- Reset asserted mid-SHIFT or mid-OUT aborts immediately. The in-flight result is discarded and never presented.

## Configuration
- FPDEC_SATURATE_EN defined, on overflow:
  - D clamps to 2^(OUT_W-1)-1 (positive) or -2^(OUT_W-1) (negative).
  - ovf=1.
- FPDEC_SATURATE_EN undefined, on overflow:
  - D is the low OUT_W bits of the exact two's-complement result (wraps).
  - ovf=1 still.
- Non-overflow results are identical in both builds.

## Test plan (OUT_W=12)
- S=0, E=3, F=22 -> D=12'h0B0 (176), ovf=0. out_valid 5 cycles after accept.
- S=1, E=0, F=1 -> D=12'hFFF, ovf=0, latency 2. S=1, E=5, F=0 -> D=12'h000, ovf=0.
- S=1, E=6, F=31 -> D=12'h840 (-1984). S=1, E=7, F=16 -> D=12'h800 (-2048), ovf=0 (exact boundary).
- S=0, E=7, F=31 (3968):
  - with FPDEC_SATURATE_EN -> D=12'h7FF, ovf=1.
  - without -> D=12'hF80, ovf=1.
  - S=0, E=6, F=32 is impossible; also check S=0, E=6, F=31 -> 12'h7C0, ovf=0.
- Backpressure: hold out_ready=0 for 4 cycles after out_valid.
  - D and ovf stay constant, in_ready stays 0.
  - Raise out_ready: out_valid drops next cycle, in_ready=1.
  - Back-to-back input accepted on that cycle.
- Drop rst_n for 1 cycle during SHIFT of E=7.
  - All outputs reach reset values asynchronously.
  - After release, no out_valid appears until a new input is accepted.
